// File: rtl/oled_rx_decoder_pkg.sv
// ---------------------------------------------------------------------------
// oled_rx_decoder_pkg
// Shared constants for the OLED panel receive path:
//   - command opcodes the parser recognises
//   - parser state encoding
//   - reset values of the display registers and page window
//   - helper that tells whether an opcode expects argument bytes
// ---------------------------------------------------------------------------
package oled_rx_decoder_pkg;

  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;
  localparam logic [7:0] OP_CHG_PUMP   = 8'h8D;
  localparam logic [7:0] OP_PRECHARGE  = 8'hD9;
  localparam logic [7:0] OP_CONTRAST   = 8'h81;
  localparam logic [7:0] OP_COM_PINS   = 8'hDA;
  localparam logic [7:0] OP_PAGE_ADDR  = 8'h22;
  localparam logic [7:0] OP_SEG_REMAP0 = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP1 = 8'hA1;
  localparam logic [7:0] OP_COM_SCAN0  = 8'hC0;
  localparam logic [7:0] OP_COM_SCAN1  = 8'hC8;

  typedef enum logic [1:0] {
    P_OP   = 2'd0,
    P_ARG1 = 2'd1,
    P_ARG2 = 2'd2
  } parserState_e;

  localparam logic [7:0] RST_CONTRAST   = 8'h7F;
  localparam logic [2:0] RST_PAGE_START = 3'd0;
  localparam logic [2:0] RST_PAGE_END   = 3'd7;

  // Opcodes that are followed by at least one argument byte.
  function automatic logic isArgOpcode(input logic [7:0] op);
    return (op == OP_CHG_PUMP) || (op == OP_PRECHARGE) || (op == OP_CONTRAST) ||
           (op == OP_COM_PINS) || (op == OP_PAGE_ADDR);
  endfunction

endpackage

// File: rtl/oled_rx_decoder_if.sv
// ---------------------------------------------------------------------------
// oled_rx_decoder_if
// Bundles the raw panel pins and the received-byte link between the SPI
// deserialiser and the command/GDRAM parser.
//   w_sclk/w_sdin/w_dcN/w_rstN : raw panel pins (asynchronous to i_clk)
//   w_rxByte/w_rxDc/w_rxValid  : one-cycle completed byte with its DC_N flag
//   w_panelRstN                : synchronised panel reset (active-low)
// Modports: host drives the pins, master is the deserialiser, slave the parser.
// ---------------------------------------------------------------------------
interface oled_rx_decoder_if;

  logic       w_sclk;
  logic       w_sdin;
  logic       w_dcN;
  logic       w_rstN;
  logic [7:0] w_rxByte;
  logic       w_rxDc;
  logic       w_rxValid;
  logic       w_panelRstN;

  modport host   (output w_sclk, w_sdin, w_dcN, w_rstN);
  modport master (input  w_sclk, w_sdin, w_dcN, w_rstN,
                  output w_rxByte, w_rxDc, w_rxValid, w_panelRstN);
  modport slave  (input  w_rxByte, w_rxDc, w_rxValid, w_panelRstN);

endinterface

// File: rtl/oled_rx_decoder_spi_rx.sv
// ---------------------------------------------------------------------------
// oled_spi_rx
// Serial front end of the panel receiver: synchronises the panel pins into
// the i_clk domain, detects SCLK rising edges, shifts SDIN in MSB first and
// presents each completed byte (with DC_N captured on its 8th bit) as a
// one-cycle valid. A partial byte is dropped after IDLE_TIMEOUT cycles
// without an SCLK rise, or while the synchronised panel reset is low.
// Ports: i_clk, i_arst_n (async, active-low), rxLink (master modport).
// ---------------------------------------------------------------------------
module oled_spi_rx
  import oled_rx_decoder_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  oled_rx_decoder_if.master         rxLink
);

  localparam int              CNT_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_TIMEOUT);

  logic [1:0]       r_sclkSync;
  logic [1:0]       r_sdinSync;
  logic [1:0]       r_dcSync;
  logic [1:0]       r_rstSync;
  logic             r_sclkPrev;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitCnt;
  logic [CNT_W-1:0] r_idleCnt;
  logic [7:0]       r_rxByte;
  logic             r_rxDc;
  logic             r_rxValid;
  logic             w_sclkRise;

  // Two-flop synchronisers for all four panel pins; SCLK and SDIN share the
  // same latency so the data bit lines up with the detected edge.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sclkSync <= '0;
      r_sdinSync <= '0;
      r_dcSync   <= '0;
      r_rstSync  <= '0;
      r_sclkPrev <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[0], rxLink.w_sclk};
      r_sdinSync <= {r_sdinSync[0], rxLink.w_sdin};
      r_dcSync   <= {r_dcSync[0],   rxLink.w_dcN};
      r_rstSync  <= {r_rstSync[0],  rxLink.w_rstN};
      r_sclkPrev <= r_sclkSync[1];
    end
  end

  assign w_sclkRise = r_sclkSync[1] & ~r_sclkPrev;

  // Shift register and bit counter; the 3-bit counter wraps to 0 after the
  // 8th bit, so the next byte starts cleanly. The idle counter saturates at
  // IDLE_MAX and keeps the bit counter cleared until SCLK moves again.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_idleCnt <= '0;
      r_rxByte  <= '0;
      r_rxDc    <= 1'b0;
      r_rxValid <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      if (!r_rstSync[1]) begin
        r_shift   <= '0;
        r_bitCnt  <= '0;
        r_idleCnt <= '0;
        r_rxByte  <= '0;
        r_rxDc    <= 1'b0;
      end else if (w_sclkRise) begin
        r_shift   <= {r_shift[6:0], r_sdinSync[1]};
        r_bitCnt  <= r_bitCnt + 3'd1;
        r_idleCnt <= '0;
        if (r_bitCnt == 3'd7) begin
          r_rxByte  <= {r_shift[6:0], r_sdinSync[1]};
          r_rxDc    <= r_dcSync[1];
          r_rxValid <= 1'b1;
        end
      end else if (r_idleCnt == IDLE_MAX) begin
        r_bitCnt <= '0;
      end else begin
        r_idleCnt <= r_idleCnt + CNT_W'(1);
      end
    end
  end

  assign rxLink.w_rxByte    = r_rxByte;
  assign rxLink.w_rxDc      = r_rxDc;
  assign rxLink.w_rxValid   = r_rxValid;
  assign rxLink.w_panelRstN = r_rstSync[1];

endmodule

// File: rtl/oled_rx_decoder.sv
// ---------------------------------------------------------------------------
// oled_rx_decoder
// Snoops an SSD1306-style OLED serial bus and reconstructs the panel state:
// GDRAM writes with their page/column address, display on/off, contrast and
// charge-pump enable, plus a strobe per command byte and a pulse on opcodes
// it does not recognise.
// Ports:
//   i_clk, i_arst_n                  system clock, async active-low reset
//   i_oled_sclk/sdin/dc_n/rst_n      panel serial bus (asynchronous)
//   o_gd_we/o_gd_addr/o_gd_data      GDRAM write port, one-cycle strobe
//   o_cmd_strobe/o_cmd_byte          per-command-byte pulse and last byte
//   o_disp_on/o_contrast/o_chg_pump_en  decoded panel registers
//   o_unknown_cmd                    pulse on an unsupported opcode
// ---------------------------------------------------------------------------
module oled_rx_decoder
  import oled_rx_decoder_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_oled_sclk,
  input  logic       i_oled_sdin,
  input  logic       i_oled_dc_n,
  input  logic       i_oled_rst_n,
  output logic       o_gd_we,
  output logic [9:0] o_gd_addr,
  output logic [7:0] o_gd_data,
  output logic       o_cmd_strobe,
  output logic [7:0] o_cmd_byte,
  output logic       o_disp_on,
  output logic [7:0] o_contrast,
  output logic       o_chg_pump_en,
  output logic       o_unknown_cmd
);

  oled_rx_decoder_if rxLink ();

  assign rxLink.w_sclk = i_oled_sclk;
  assign rxLink.w_sdin = i_oled_sdin;
  assign rxLink.w_dcN  = i_oled_dc_n;
  assign rxLink.w_rstN = i_oled_rst_n;

  oled_spi_rx #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_spiRx (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .rxLink   (rxLink)
  );

  parserState_e r_state,    w_nextState;
  logic [7:0]   r_op,       w_op;
  logic [2:0]   r_page,     w_page;
  logic [6:0]   r_col,      w_col;
  logic [2:0]   r_pageStart, w_pageStart;
  logic [2:0]   r_pageEnd,  w_pageEnd;
  logic         r_dispOn,   w_dispOn;
  logic [7:0]   r_contrast, w_contrast;
  logic         r_chgPump,  w_chgPump;
  logic         r_gdWe,     w_gdWe;
  logic [9:0]   r_gdAddr,   w_gdAddr;
  logic [7:0]   r_gdData,   w_gdData;
  logic         r_cmdStrobe, w_cmdStrobe;
  logic [7:0]   r_cmdByte,  w_cmdByte;
  logic         r_unknown,  w_unknown;
  logic [7:0]   w_byte;

  assign w_byte = rxLink.w_rxByte;

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state     <= P_OP;
      r_op        <= '0;
      r_page      <= RST_PAGE_START;
      r_col       <= '0;
      r_pageStart <= RST_PAGE_START;
      r_pageEnd   <= RST_PAGE_END;
      r_dispOn    <= 1'b0;
      r_contrast  <= RST_CONTRAST;
      r_chgPump   <= 1'b0;
      r_gdWe      <= 1'b0;
      r_gdAddr    <= '0;
      r_gdData    <= '0;
      r_cmdStrobe <= 1'b0;
      r_cmdByte   <= '0;
      r_unknown   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_op        <= w_op;
      r_page      <= w_page;
      r_col       <= w_col;
      r_pageStart <= w_pageStart;
      r_pageEnd   <= w_pageEnd;
      r_dispOn    <= w_dispOn;
      r_contrast  <= w_contrast;
      r_chgPump   <= w_chgPump;
      r_gdWe      <= w_gdWe;
      r_gdAddr    <= w_gdAddr;
      r_gdData    <= w_gdData;
      r_cmdStrobe <= w_cmdStrobe;
      r_cmdByte   <= w_cmdByte;
      r_unknown   <= w_unknown;
    end
  end

  // Parser next-state. Data bytes only touch the GDRAM cursor, so a data
  // byte arriving between an opcode and its argument leaves the parser where
  // it was. The synchronised panel reset overrides everything.
  always_comb begin
    w_nextState = r_state;
    w_op        = r_op;
    w_page      = r_page;
    w_col       = r_col;
    w_pageStart = r_pageStart;
    w_pageEnd   = r_pageEnd;
    w_dispOn    = r_dispOn;
    w_contrast  = r_contrast;
    w_chgPump   = r_chgPump;
    w_gdWe      = 1'b0;
    w_gdAddr    = r_gdAddr;
    w_gdData    = r_gdData;
    w_cmdStrobe = 1'b0;
    w_cmdByte   = r_cmdByte;
    w_unknown   = 1'b0;

    if (!rxLink.w_panelRstN) begin
      w_nextState = P_OP;
      w_op        = '0;
      w_page      = RST_PAGE_START;
      w_col       = '0;
      w_pageStart = RST_PAGE_START;
      w_pageEnd   = RST_PAGE_END;
      w_dispOn    = 1'b0;
      w_contrast  = RST_CONTRAST;
      w_chgPump   = 1'b0;
      w_gdAddr    = '0;
      w_gdData    = '0;
      w_cmdByte   = '0;
    end else if (rxLink.w_rxValid) begin
      if (rxLink.w_rxDc) begin
        w_gdWe   = 1'b1;
        w_gdAddr = {r_page, r_col};
        w_gdData = w_byte;
        w_col    = r_col + 7'd1;
        // End of a row: wrap inside the page window; plain increment wraps
        // 7 -> 0 when the window itself wraps around.
        if (r_col == 7'd127) begin
          w_page = (r_page == r_pageEnd) ? r_pageStart : r_page + 3'd1;
        end
      end else begin
        w_cmdStrobe = 1'b1;
        w_cmdByte   = w_byte;
        case (r_state)
          P_OP: begin
            if (isArgOpcode(w_byte)) begin
              w_op        = w_byte;
              w_nextState = P_ARG1;
            end else begin
              case (w_byte) inside
                OP_DISP_OFF:                  w_dispOn = 1'b0;
                OP_DISP_ON:                   w_dispOn = 1'b1;
                OP_SEG_REMAP0, OP_SEG_REMAP1,
                OP_COM_SCAN0,  OP_COM_SCAN1:  w_unknown = 1'b0;
                [8'h00:8'h0F]:                w_col[3:0] = w_byte[3:0];
                [8'h10:8'h17]:                w_col[6:4] = w_byte[2:0];
                [8'hB0:8'hB7]:                w_page = w_byte[2:0];
                default:                      w_unknown = 1'b1;
              endcase
            end
          end
          P_ARG1: begin
            if (r_op == OP_CHG_PUMP) w_chgPump   = w_byte[2];
            if (r_op == OP_CONTRAST) w_contrast  = w_byte;
            if (r_op == OP_PAGE_ADDR) w_pageStart = w_byte[2:0];
            w_nextState = (r_op == OP_PAGE_ADDR) ? P_ARG2 : P_OP;
          end
          P_ARG2: begin
            w_pageEnd   = w_byte[2:0];
            w_page      = r_pageStart;
            w_col       = '0;
            w_nextState = P_OP;
          end
          default: w_nextState = P_OP;
        endcase
      end
    end
  end

  assign o_gd_we       = r_gdWe;
  assign o_gd_addr     = r_gdAddr;
  assign o_gd_data     = r_gdData;
  assign o_cmd_strobe  = r_cmdStrobe;
  assign o_cmd_byte    = r_cmdByte;
  assign o_disp_on     = r_dispOn;
  assign o_contrast    = r_contrast;
  assign o_chg_pump_en = r_chgPump;
  assign o_unknown_cmd = r_unknown;

endmodule

// File: tb/tb_oled_rx_decoder.sv
// ---------------------------------------------------------------------------
// tb_oled_rx_decoder
// Drives the panel serial bus with randomised SCLK phases and compares every
// GDRAM write / command strobe against a behavioural model of the panel
// command set kept in this bench.
// ---------------------------------------------------------------------------
module tb_oled_rx_decoder;

  localparam int IDLE_TIMEOUT = 64;

  logic       clk;
  logic       arstN;
  logic       gdWe;
  logic [9:0] gdAddr;
  logic [7:0] gdData;
  logic       cmdStrobe;
  logic [7:0] cmdByte;
  logic       dispOn;
  logic [7:0] contrast;
  logic       chgPumpEn;
  logic       unknownCmd;

  oled_rx_decoder_if pins ();

  oled_rx_decoder #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .i_clk         (clk),
    .i_arst_n      (arstN),
    .i_oled_sclk   (pins.w_sclk),
    .i_oled_sdin   (pins.w_sdin),
    .i_oled_dc_n   (pins.w_dcN),
    .i_oled_rst_n  (pins.w_rstN),
    .o_gd_we       (gdWe),
    .o_gd_addr     (gdAddr),
    .o_gd_data     (gdData),
    .o_cmd_strobe  (cmdStrobe),
    .o_cmd_byte    (cmdByte),
    .o_disp_on     (dispOn),
    .o_contrast    (contrast),
    .o_chg_pump_en (chgPumpEn),
    .o_unknown_cmd (unknownCmd)
  );

  // Clock and a cycle stamp used to measure strobe latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycCnt = 0;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  // Observed output events, recorded on the falling edge.
  typedef struct {
    logic       we;
    logic       cmd;
    logic       unk;
    logic [9:0] addr;
    logic [7:0] data;
    logic [7:0] cmdb;
    logic       disp;
    logic [7:0] contrast;
    logic       pump;
    int         cyc;
  } obsT;

  obsT obsQ[$];
  int  cmdCnt = 0;
  int  unkCnt = 0;

  always @(negedge clk) begin
    if (gdWe || cmdStrobe || unknownCmd) begin
      obsT ev;
      ev.we = gdWe; ev.cmd = cmdStrobe; ev.unk = unknownCmd;
      ev.addr = gdAddr; ev.data = gdData; ev.cmdb = cmdByte;
      ev.disp = dispOn; ev.contrast = contrast; ev.pump = chgPumpEn;
      ev.cyc = cycCnt;
      obsQ.push_back(ev);
    end
    if (cmdStrobe)  cmdCnt <= cmdCnt + 1;
    if (unknownCmd) unkCnt <= unkCnt + 1;
  end

  // Checking.
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Behavioural model of the panel: a cursor (page, column) over a 8x128
  // byte array, a page window, and the decoded registers.
  int mPage, mCol, mPStart, mPEnd, mArgStep, mOp, mDisp, mContrast, mPump;

  typedef struct {
    bit isData;
    int addr;
    int data;
    int cmd;
    bit unk;
    int disp;
    int contrast;
    int pump;
  } expT;

  task automatic modelReset();
    mPage = 0; mCol = 0; mPStart = 0; mPEnd = 7; mArgStep = 0; mOp = 0;
    mDisp = 0; mContrast = 8'h7F; mPump = 0;
  endtask

  function automatic expT modelApply(input int b, input bit dc);
    expT e;
    e.isData = dc; e.addr = 0; e.data = 0; e.cmd = 0; e.unk = 0;
    if (dc) begin
      e.addr = mPage * 128 + mCol;
      e.data = b;
      mCol = mCol + 1;
      if (mCol == 128) begin
        mCol = 0;
        if (mPage == mPEnd) mPage = mPStart;
        else mPage = (mPage + 1) % 8;
      end
    end else begin
      e.cmd = b;
      if (mArgStep == 0) begin
        if (b == 'hAE) mDisp = 0;
        else if (b == 'hAF) mDisp = 1;
        else if (b == 'hA0 || b == 'hA1 || b == 'hC0 || b == 'hC8) mDisp = mDisp;
        else if (b == 'h8D || b == 'hD9 || b == 'h81 || b == 'hDA || b == 'h22) begin
          mOp = b; mArgStep = 1;
        end
        else if (b <= 'h0F) mCol = (mCol / 16) * 16 + b;
        else if (b <= 'h17) mCol = (b - 'h10) * 16 + (mCol % 16);
        else if (b >= 'hB0 && b <= 'hB7) mPage = b - 'hB0;
        else e.unk = 1;
      end else if (mArgStep == 1) begin
        if (mOp == 'h8D) mPump = (b / 4) % 2;
        if (mOp == 'h81) mContrast = b;
        if (mOp == 'h22) begin mPStart = b % 8; mArgStep = 2; end
        else mArgStep = 0;
      end else begin
        mPEnd = b % 8; mPage = mPStart; mCol = 0; mArgStep = 0;
      end
    end
    e.disp = mDisp; e.contrast = mContrast; e.pump = mPump;
    return e;
  endfunction

  // Serial driver: data changes while SCLK is low, each phase 3..4 cycles.
  int riseCyc = 0;

  task automatic sendBits(input logic [7:0] b, input bit dc, input int nBits);
    pins.w_dcN = dc;
    for (int i = 7; i > 7 - nBits; i--) begin
      pins.w_sdin = b[i];
      repeat ($urandom_range(3, 4)) @(negedge clk);
      pins.w_sclk = 1'b1;
      riseCyc = cycCnt;
      repeat ($urandom_range(3, 4)) @(negedge clk);
      pins.w_sclk = 1'b0;
    end
  endtask

  // Send one byte and compare the resulting event against the model.
  task automatic applyStimulus(input int b, input bit dc);
    expT e;
    obsT ev;
    int  waited;
    e = modelApply(b, dc);
    sendBits(8'(b), dc, 8);
    waited = 0;
    while (obsQ.size() == 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("eventSeen", 32'(obsQ.size() != 0), 32'd1);
    if (obsQ.size() != 0) begin
      ev = obsQ.pop_front();
      checkOutput("latency", 32'((ev.cyc - riseCyc) >= 3 && (ev.cyc - riseCyc) <= 5), 32'd1);
      checkOutput("gdWe", 32'(ev.we), 32'(e.isData));
      checkOutput("cmdStrobe", 32'(ev.cmd), 32'(!e.isData));
      checkOutput("unknown", 32'(ev.unk), 32'(e.unk));
      if (e.isData) begin
        checkOutput("gdAddr", 32'(ev.addr), 32'(e.addr));
        checkOutput("gdData", 32'(ev.data), 32'(e.data));
      end else begin
        checkOutput("cmdByte", 32'(ev.cmdb), 32'(e.cmd));
        checkOutput("dispOn", 32'(ev.disp), 32'(e.disp));
        checkOutput("contrast", 32'(ev.contrast), 32'(e.contrast));
        checkOutput("chgPump", 32'(ev.pump), 32'(e.pump));
      end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #(900_000);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cmd0, unk0;
    int b;
    logic [7:0] cmdList [12];

    arstN = 1'b0;
    pins.w_sclk = 1'b0; pins.w_sdin = 1'b0; pins.w_dcN = 1'b0; pins.w_rstN = 1'b1;
    modelReset();
    repeat (5) @(negedge clk);

    // Reset values while i_arst_n is low.
    checkOutput("rstGdWe", 32'(gdWe), 32'd0);
    checkOutput("rstGdAddr", 32'(gdAddr), 32'd0);
    checkOutput("rstGdData", 32'(gdData), 32'd0);
    checkOutput("rstCmdStrobe", 32'(cmdStrobe), 32'd0);
    checkOutput("rstCmdByte", 32'(cmdByte), 32'd0);
    checkOutput("rstDispOn", 32'(dispOn), 32'd0);
    checkOutput("rstContrast", 32'(contrast), 32'h7F);
    checkOutput("rstChgPump", 32'(chgPumpEn), 32'd0);
    checkOutput("rstUnknown", 32'(unknownCmd), 32'd0);
    arstN = 1'b1;
    repeat (6) @(negedge clk);

    // Power-up command sequence.
    #1; cmd0 = cmdCnt; unk0 = unkCnt;
    @(negedge clk);
    foreach (cmdList[i]) cmdList[i] = 8'h00;
    cmdList[0] = 8'hAE; cmdList[1] = 8'h8D; cmdList[2] = 8'h14; cmdList[3] = 8'hD9;
    cmdList[4] = 8'hF1; cmdList[5] = 8'h81; cmdList[6] = 8'hFF; cmdList[7] = 8'hAF;
    for (int i = 0; i < 8; i++) applyStimulus(cmdList[i], 1'b0);
    repeat (2) @(negedge clk); #1;
    checkOutput("initCmdCount", 32'(cmdCnt - cmd0), 32'd8);
    checkOutput("initUnkCount", 32'(unkCnt - unk0), 32'd0);
    checkOutput("initPump", 32'(chgPumpEn), 32'd1);
    checkOutput("initContrast", 32'(contrast), 32'hFF);
    checkOutput("initDisp", 32'(dispOn), 32'd1);
    @(negedge clk);

    // Single-page window: 128 bytes fill page 2, the 129th wraps to its start.
    applyStimulus('h22, 1'b0); applyStimulus('h02, 1'b0);
    applyStimulus('h02, 1'b0); applyStimulus('h10, 1'b0);
    for (int i = 0; i < 129; i++) applyStimulus(i % 128, 1'b1);

    // Two-page window 6..7: 256 bytes, then wrap back to page 6.
    applyStimulus('h22, 1'b0); applyStimulus('h06, 1'b0); applyStimulus('h07, 1'b0);
    for (int i = 0; i < 257; i++) applyStimulus($urandom_range(0, 255), 1'b1);

    // Partial byte followed by a long idle is discarded.
    applyStimulus('hAE, 1'b0);
    sendBits(8'hA5, 1'b0, 5);
    repeat (IDLE_TIMEOUT + 2) @(negedge clk);
    checkOutput("timeoutNoEvent", 32'(obsQ.size()), 32'd0);
    #1; cmd0 = cmdCnt;
    @(negedge clk);
    applyStimulus('hAF, 1'b0);
    repeat (2) @(negedge clk); #1;
    checkOutput("timeoutCmdCount", 32'(cmdCnt - cmd0), 32'd1);
    checkOutput("timeoutDisp", 32'(dispOn), 32'd1);
    @(negedge clk);

    // Unsupported opcode, then normal decoding resumes.
    #1; unk0 = unkCnt;
    @(negedge clk);
    applyStimulus('h5A, 1'b0);
    applyStimulus('hAE, 1'b0);
    applyStimulus('hAF, 1'b0);
    repeat (2) @(negedge clk); #1;
    checkOutput("unkPulseCount", 32'(unkCnt - unk0), 32'd1);
    @(negedge clk);

    // Panel reset in the middle of a byte.
    applyStimulus('h81, 1'b0); applyStimulus('h20, 1'b0);
    applyStimulus('h40, 1'b1);
    sendBits(8'hFF, 1'b1, 4);
    pins.w_rstN = 1'b0;
    repeat (8) @(negedge clk);
    pins.w_rstN = 1'b1;
    repeat (6) @(negedge clk);
    modelReset();
    checkOutput("panelRstNoEvent", 32'(obsQ.size()), 32'd0);
    checkOutput("panelRstContrast", 32'(contrast), 32'h7F);
    checkOutput("panelRstDisp", 32'(dispOn), 32'd0);
    applyStimulus('hAF, 1'b0);
    applyStimulus('h3C, 1'b1);

    // Randomised mix of commands and data bytes.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus($urandom_range(0, 255), 1'b1);
      end else begin
        case ($urandom_range(0, 9))
          0: b = 'hAE;
          1: b = 'hAF;
          2: b = 'h8D;
          3: b = 'h81;
          4: b = 'h22;
          5: b = $urandom_range(0, 'h17);
          6: b = 'hB0 + $urandom_range(0, 7);
          7: b = ($urandom_range(0, 1) == 1) ? 'hA1 : 'hC8;
          8: b = ($urandom_range(0, 1) == 1) ? 'hD9 : 'hDA;
          default: b = $urandom_range(0, 255);
        endcase
        applyStimulus(b, 1'b0);
      end
    end

    repeat (10) @(negedge clk);
    checkOutput("noStrayEvents", 32'(obsQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
